// File: rtl/csel_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined carry-select adder.
package csel_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int calc_nblk(input int width, input int block);
    return width / block;
  endfunction

  function automatic int calc_nstg(input int nblk, input int bps);
    return (nblk + bps - 1) / bps;
  endfunction

  // Index of the last block resolved by stage stg; the final stage may be short.
  function automatic int stage_last_blk(input int stg, input int nblk, input int bps);
    int last;
    last = ((stg + 1) * bps > nblk) ? nblk : (stg + 1) * bps;
    return last - 1;
  endfunction

  function automatic bit params_ok(input int width, input int block, input int bps);
    return (width > 0) && (block > 0) && (bps > 0) && ((width % block) == 0);
  endfunction

endpackage

// File: rtl/csel_block.sv
// One carry-select slice: two ripple chains (carry-in 0 and 1) selected by the real carry.
module csel_block #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  output logic [W-1:0] sum,
  output logic         c_out,
  output logic         c_msb_in
);

  logic [W-1:0] s0_s;
  logic [W-1:0] s1_s;
  logic [W:0]   k0_s;
  logic [W:0]   k1_s;

  always_comb begin
    s0_s    = '0;
    s1_s    = '0;
    k0_s    = '0;
    k1_s    = '0;
    k0_s[0] = 1'b0;
    k1_s[0] = 1'b1;
    for (int i = 0; i < W; i++) begin
      s0_s[i]   = a[i] ^ b[i] ^ k0_s[i];
      k0_s[i+1] = (a[i] & b[i]) | (k0_s[i] & (a[i] ^ b[i]));
      s1_s[i]   = a[i] ^ b[i] ^ k1_s[i];
      k1_s[i+1] = (a[i] & b[i]) | (k1_s[i] & (a[i] ^ b[i]));
    end
  end

  assign sum      = c_in ? s1_s : s0_s;
  assign c_out    = c_in ? k1_s[W] : k0_s[W];
  assign c_msb_in = c_in ? k1_s[W-1] : k0_s[W-1];

endmodule

// File: rtl/csel_adder_pipe.sv
// Pipelined carry-select adder/subtractor with valid/ready flow control.
// Each stage resolves BPS blocks; a single global enable stalls the whole pipe.
module csel_adder_pipe #(
  parameter int WIDTH = 64,
  parameter int BLOCK = 8,
  parameter int BPS   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  import csel_pkg::*;

  localparam int NBLK = calc_nblk(WIDTH, BLOCK);
  localparam int NSTG = calc_nstg(NBLK, BPS);

  if (!params_ok(WIDTH, BLOCK, BPS)) begin : g_param_err
    $error("csel_adder_pipe: WIDTH must be a positive multiple of BLOCK");
  end

  logic [WIDTH-1:0] st_a_s   [NSTG];
  logic [WIDTH-1:0] st_bx_s  [NSTG];
  logic [WIDTH-1:0] st_sum_s [NSTG];
  logic [NSTG-1:0]  st_c_s;
  logic [NSTG-1:0]  st_v_s;

  logic [WIDTH-1:0] a_q   [NSTG];
  logic [WIDTH-1:0] a_d   [NSTG];
  logic [WIDTH-1:0] bx_q  [NSTG];
  logic [WIDTH-1:0] bx_d  [NSTG];
  logic [WIDTH-1:0] sum_q [NSTG];
  logic [WIDTH-1:0] sum_d [NSTG];
  logic [NSTG-1:0]  c_q;
  logic [NSTG-1:0]  c_d;
  logic [NSTG-1:0]  v_q;
  logic [NSTG-1:0]  v_d;
  logic             msb_c_q;
  logic             msb_c_d;

  logic [BLOCK-1:0] blk_sum_s [NBLK];
  logic [NBLK-1:0]  blk_cmsb_s;
  logic             unused_cmsb_s;
  logic             en_s;

  assign en_s     = !out_valid || out_ready;
  assign in_ready = en_s;

  // Stage inputs: stage 0 sees the ports, later stages see the previous register.
  always_comb begin
    st_a_s[0]   = a;
    st_bx_s[0]  = (sub == OP_SUB) ? ~b : b;
    st_c_s[0]   = cin ^ sub;
    st_sum_s[0] = '0;
    st_v_s[0]   = in_valid;
    for (int s = 1; s < NSTG; s++) begin
      st_a_s[s]   = a_q[s-1];
      st_bx_s[s]  = bx_q[s-1];
      st_c_s[s]   = c_q[s-1];
      st_sum_s[s] = sum_q[s-1];
      st_v_s[s]   = v_q[s-1];
    end
  end

  for (genvar j = 0; j < NBLK; j++) begin : g_blk
    localparam int STG = j / BPS;
    logic             c_in_s;
    logic             c_out_s;
    logic             c_msb_s;
    logic [BLOCK-1:0] sum_s;

    if ((j % BPS) == 0) begin : g_first
      assign c_in_s = st_c_s[STG];
    end else begin : g_chain
      assign c_in_s = g_blk[j-1].c_out_s;
    end

    csel_block #(.W(BLOCK)) u_blk (
      .a        (st_a_s[STG][j*BLOCK +: BLOCK]),
      .b        (st_bx_s[STG][j*BLOCK +: BLOCK]),
      .c_in     (c_in_s),
      .sum      (sum_s),
      .c_out    (c_out_s),
      .c_msb_in (c_msb_s)
    );

    assign blk_sum_s[j]  = sum_s;
    assign blk_cmsb_s[j] = c_msb_s;

    // The last block of each stage hands its carry to the next stage.
    if (j == stage_last_blk(STG, NBLK, BPS)) begin : g_stage_carry
      assign c_d[STG] = c_out_s;
    end
  end

  assign msb_c_d       = blk_cmsb_s[NBLK-1];
  assign unused_cmsb_s = ^blk_cmsb_s;

  always_comb begin
    for (int s = 0; s < NSTG; s++) begin
      a_d[s]   = st_a_s[s];
      bx_d[s]  = st_bx_s[s];
      sum_d[s] = st_sum_s[s];
      v_d[s]   = st_v_s[s];
    end
    for (int j = 0; j < NBLK; j++) begin
      sum_d[j / BPS][j*BLOCK +: BLOCK] = blk_sum_s[j];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      v_q     <= '0;
      c_q     <= '0;
      msb_c_q <= 1'b0;
      for (int s = 0; s < NSTG; s++) begin
        a_q[s]   <= '0;
        bx_q[s]  <= '0;
        sum_q[s] <= '0;
      end
    end else if (en_s) begin
      v_q     <= v_d;
      c_q     <= c_d;
      msb_c_q <= msb_c_d;
      for (int s = 0; s < NSTG; s++) begin
        a_q[s]   <= a_d[s];
        bx_q[s]  <= bx_d[s];
        sum_q[s] <= sum_d[s];
      end
    end
  end

  assign out_valid = v_q[NSTG-1];
  assign sum       = sum_q[NSTG-1];
  assign cout      = c_q[NSTG-1];
  assign ovf       = msb_c_q ^ c_q[NSTG-1];

endmodule

// File: tb/tb_csel_adder_pipe.sv
// Directed/table-driven bench for csel_adder_pipe (64/8/2 pipe plus a 32/4/8 single-stage build).
module tb_csel_adder_pipe;

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic        sub;
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  typedef struct packed {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  localparam int NSTG = 4;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [63:0] a, b, sum;

  logic s_in_valid, s_in_ready, s_cin, s_sub, s_out_valid, s_out_ready, s_cout, s_ovf;
  logic [31:0] s_a, s_b, s_sum;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  csel_adder_pipe #(.WIDTH(64), .BLOCK(8), .BPS(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
  );

  csel_adder_pipe #(.WIDTH(32), .BLOCK(4), .BPS(8)) dut_small (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .a(s_a), .b(s_b), .cin(s_cin), .sub(s_sub), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .sum(s_sum), .cout(s_cout), .ovf(s_ovf)
  );

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endtask

  function automatic res_t model(input logic [63:0] ma, input logic [63:0] mb,
                                 input logic mcin, input logic msub);
    logic [63:0] bx;
    logic [64:0] r;
    res_t res;
    bx = msub ? ~mb : mb;
    r = {1'b0, ma} + {1'b0, bx} + {64'd0, mcin ^ msub};
    res.sum  = r[63:0];
    res.cout = r[64];
    res.ovf  = (ma[63] == bx[63]) && (r[63] != ma[63]);
    return res;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [10];
    logic [63:0] ra [16];
    logic [63:0] rb [16];
    logic        rc [16];
    logic        rs [16];
    res_t exp_q [$];
    res_t e;
    int sent, got, cyc;
    logic stalled_prev;
    logic [63:0] prev_sum;

    vecs[0] = '{a:64'hFFFF_FFFF_FFFF_FFFF, b:64'd1, cin:1'b0, sub:1'b0, sum:64'd0, cout:1'b1, ovf:1'b0};
    vecs[1] = '{a:64'd5, b:64'd7, cin:1'b0, sub:1'b1, sum:64'hFFFF_FFFF_FFFF_FFFE, cout:1'b0, ovf:1'b0};
    vecs[2] = '{a:64'd5, b:64'd5, cin:1'b1, sub:1'b1, sum:64'hFFFF_FFFF_FFFF_FFFF, cout:1'b0, ovf:1'b0};
    vecs[3] = '{a:64'h7FFF_FFFF_FFFF_FFFF, b:64'd1, cin:1'b0, sub:1'b0, sum:64'h8000_0000_0000_0000, cout:1'b0, ovf:1'b1};
    vecs[4] = '{a:64'h8000_0000_0000_0000, b:64'd1, cin:1'b0, sub:1'b1, sum:64'h7FFF_FFFF_FFFF_FFFF, cout:1'b1, ovf:1'b1};
    vecs[5] = '{a:64'd0, b:64'd0, cin:1'b1, sub:1'b0, sum:64'd1, cout:1'b0, ovf:1'b0};
    vecs[6] = '{a:64'd10, b:64'd3, cin:1'b0, sub:1'b1, sum:64'd7, cout:1'b1, ovf:1'b0};
    vecs[7] = '{a:64'h00FF_00FF_00FF_00FF, b:64'h0001_0001_0001_0001, cin:1'b0, sub:1'b0, sum:64'h0100_0100_0100_0100, cout:1'b0, ovf:1'b0};
    vecs[8] = '{a:64'h0000_0000_FFFF_FFFF, b:64'd1, cin:1'b0, sub:1'b0, sum:64'h0000_0001_0000_0000, cout:1'b0, ovf:1'b0};
    vecs[9] = '{a:64'hFFFF_FFFF_FFFF_FFFF, b:64'd0, cin:1'b1, sub:1'b0, sum:64'd0, cout:1'b1, ovf:1'b0};

    // Reset held for two edges with a live input beat.
    rst = 1'b0; in_valid = 1'b1; a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'd1; cin = 1'b0; sub = 1'b0;
    out_ready = 1'b1;
    s_in_valid = 1'b0; s_a = 32'd0; s_b = 32'd0; s_cin = 1'b0; s_sub = 1'b0; s_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_out_valid", out_valid, 1'b0);
    chk64("rst_sum", sum, 64'd0);
    chk1("rst_cout", cout, 1'b0);
    chk1("rst_ovf", ovf, 1'b0);
    chk1("rst_small_valid", s_out_valid, 1'b0);
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk1("rst_in_ready", in_ready, 1'b1);
    chk1("rst_idle_valid", out_valid, 1'b0);

    // Table vectors: one beat each, result expected exactly NSTG cycles later.
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; a = vecs[i].a; b = vecs[i].b; cin = vecs[i].cin; sub = vecs[i].sub;
      for (int c = 1; c <= NSTG; c++) begin
        @(posedge clk);
        #1;
        if (c == 1) in_valid = 1'b0;
        if (c < NSTG) begin
          chk1($sformatf("vec%0d_early_c%0d", i, c), out_valid, 1'b0);
        end else begin
          chk1($sformatf("vec%0d_valid", i), out_valid, 1'b1);
          chk64($sformatf("vec%0d_sum", i), sum, vecs[i].sum);
          chk1($sformatf("vec%0d_cout", i), cout, vecs[i].cout);
          chk1($sformatf("vec%0d_ovf", i), ovf, vecs[i].ovf);
        end
      end
    end
    @(posedge clk);
    #1;

    // Backpressure: 16 random beats, out_ready pattern 1,0,0,1.
    for (int i = 0; i < 16; i++) begin
      ra[i] = {$urandom(), $urandom()};
      rb[i] = {$urandom(), $urandom()};
      rc[i] = 1'($urandom_range(0, 1));
      rs[i] = 1'($urandom_range(0, 1));
    end
    sent = 0; got = 0; cyc = 0; stalled_prev = 1'b0; prev_sum = 64'd0;
    while (got < 16 && cyc < 300) begin
      out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      if (sent < 16) begin
        in_valid = 1'b1; a = ra[sent]; b = rb[sent]; cin = rc[sent]; sub = rs[sent];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (stalled_prev) begin
        chk1("bp_stall_valid", out_valid, 1'b1);
        chk64("bp_stall_sum", sum, prev_sum);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk1("bp_spurious_result", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk64($sformatf("bp_sum%0d", got), sum, e.sum);
          chk1($sformatf("bp_cout%0d", got), cout, e.cout);
          chk1($sformatf("bp_ovf%0d", got), ovf, e.ovf);
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, cin, sub));
        sent++;
      end
      stalled_prev = out_valid && !out_ready;
      prev_sum = sum;
      @(posedge clk);
      #1;
      cyc++;
    end
    chk64("bp_result_count", 64'(got), 64'd16);
    out_ready = 1'b1; in_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      chk1("bp_no_extra", out_valid, 1'b0);
    end

    // Three beats in flight, then a one-cycle reset.
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; a = 64'(k + 1); b = 64'd1; cin = 1'b0; sub = 1'b0;
      @(posedge clk);
      #1;
      chk1("mf_pre_valid", out_valid, 1'b0);
    end
    in_valid = 1'b0; rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk1("mf_post_valid", out_valid, 1'b0);
      @(posedge clk);
      #1;
    end

    // Single-stage build: latency 1.
    s_in_valid = 1'b1; s_a = 32'hFFFF_FFFF; s_b = 32'd1; s_cin = 1'b0; s_sub = 1'b0;
    @(posedge clk);
    #1;
    s_a = 32'h7FFF_FFFF; s_b = 32'd1;
    chk1("s_valid0", s_out_valid, 1'b1);
    chk64("s_sum0", 64'(s_sum), 64'd0);
    chk1("s_cout0", s_cout, 1'b1);
    chk1("s_ovf0", s_ovf, 1'b0);
    @(posedge clk);
    #1;
    s_a = 32'd3; s_b = 32'd5; s_sub = 1'b1;
    chk64("s_sum1", 64'(s_sum), 64'h0000_0000_8000_0000);
    chk1("s_cout1", s_cout, 1'b0);
    chk1("s_ovf1", s_ovf, 1'b1);
    @(posedge clk);
    #1;
    s_in_valid = 1'b0;
    chk64("s_sum2", 64'(s_sum), 64'h0000_0000_FFFF_FFFE);
    chk1("s_cout2", s_cout, 1'b0);
    @(posedge clk);
    #1;
    chk1("s_drained", s_out_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/csel_adder_pipe.md
Name: csel_adder_pipe

Overview:
- Parametrised, pipelined carry-select adder/subtractor for the datapath library.
- Generalises the fixed-width carry-select adders in three ways: width, block size and pipeline depth are parameters, and it adds a subtract mode.
- Adds a valid/ready streaming handshake with backpressure.
- Reports carry-out and signed overflow per transaction.

Parameters:
- WIDTH, 64, operand/result width; must be a multiple of BLOCK.
- BLOCK, 8, bits per carry-select block.
- BPS, 2, carry-select blocks evaluated per pipeline stage.
- Derived: NBLK = WIDTH/BLOCK; NSTG = ceil(NBLK/BPS) = pipeline latency in cycles.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-low.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in (add) / borrow-in (sub).
- sub  in  1  0 = A+B+cin; 1 = A-B-cin.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  carry out of MSB; in sub mode, 1 = no borrow.
- ovf  out  1  signed overflow.

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-low. While rst=0 at a rising edge, every stage valid bit clears, and out_valid, sum, cout and ovf all go to 0. in_ready reads 1 in the first cycle after rst returns high.
- Arithmetic:
  - Effective operand: bx = sub ? ~b : b.
  - Effective carry-in: c0 = cin ^ sub.
  - {cout, sum} = a + bx + c0, WIDTH+1 bits.
  - ovf = carry into MSB XOR cout.
- Carry-select structure:
  - Each block computes two ripple chains in parallel, with carry-in fixed 0 and fixed 1.
  - The real incoming carry muxes the sum bits and the block carry-out.
  - Block 0 uses c0 directly.
- Pipelining:
  - Stage k (0..NSTG-1) resolves blocks k*BPS .. min((k+1)*BPS, NBLK)-1.
  - Each stage registers: the unresolved operand slices, the resolved sum bits so far, the carry into the next block, the MSB carry-in (last stage only), and a valid bit.
  - Latency is exactly NSTG cycles from the in_valid&&in_ready edge to out_valid=1, with no stall.
- Handshake:
  - Global pipeline enable en = !out_valid || out_ready; in_ready = en.
  - On en=1, all stages advance one step. The stage-0 valid bit loads in_valid.
  - On en=0, every register holds.
  - While out_valid=1 && out_ready=0: sum, cout and ovf stay stable, and no beat is accepted.
- Bubbles: an invalid beat advances like data and never asserts out_valid. Full throughput is 1 result/cycle when out_ready=1.
- Ordering: results leave in acceptance order; no beat is dropped or duplicated.
- Simultaneous events:
  - out_ready=1 with a new input in the same cycle: the output register takes the next stage's beat and the input enters stage 0, both in that cycle.
  - Reset mid-operation: all in-flight beats are discarded; no partial result appears after reset.
- Boundaries:
  - NSTG=1: single registered stage, latency 1.
  - NBLK not a multiple of BPS: the last stage resolves the remaining blocks.
  - WIDTH%BLOCK != 0: elaboration error.

Decomposition:
- Shared package csel_pkg:
  - NBLK/NSTG derivation functions.
  - Elaboration checks.
  - Opcode constants OP_ADD=0, OP_SUB=1.
- Sub-module csel_block:
  - Parametrised BLOCK-wide carry-select slice.
  - Inputs: a, b, c_in.
  - Outputs: sum, c_out, c_msb_in (the carry into the slice MSB, used for ovf).
- The pipe generates NBLK csel_block instances.

Test Plan (WIDTH=64, BLOCK=8, BPS=2, so NSTG=4, unless noted):
1. Reset: hold rst=0 for 2 cycles with in_valid=1 -> out_valid=0, sum=0, cout=0, ovf=0; in_ready=1 in the first cycle after release.
2. Full carry ripple: a=64'hFFFF_FFFF_FFFF_FFFF, b=1, cin=0, sub=0 -> exactly 4 cycles later sum=0, cout=1, ovf=0.
3. Subtract:
   - a=5, b=7, cin=0, sub=1 -> sum=64'hFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0.
   - a=5, b=5, cin=1, sub=1 -> sum=all ones, cout=0.
4. Signed overflow: a=64'h7FFF_FFFF_FFFF_FFFF, b=1, add -> sum=64'h8000_0000_0000_0000, ovf=1, cout=0.
5. Backpressure: 16 back-to-back random beats with out_ready pattern 1,0,0,1 repeating -> all 16 results match the model, in order, with no loss or duplication; sum stays stable during every stall.
6. Reset mid-flight and parameter sweep:
   - 3 beats in flight, then rst=0 for 1 cycle -> no out_valid for any of them.
   - Rebuild with WIDTH=32, BLOCK=4, BPS=8 -> latency 1; 0xFFFFFFFF+1 gives sum=0, cout=1.
